julia_write_arbiter: RTL and testbench
======================================

JULIA_WRITE_ARBITER -- requirements
Module: julia_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of Julia pixel-engine requesters sharing one Avalon write master.
REQ-002 SHALL have parameter ADDRWIDTH, default 26, Avalon master address width.
REQ-003 SHALL have parameter DATAWIDTH, default 32, pixel word width.
REQ-004 SHALL have parameter FRAME_PIXELS, default 307200, pixel writes per frame (640x480).
REQ-005 SHALL have parameter CNTWIDTH, default 20, pixel counter width.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have port frame_start, input, 1, single-cycle frame start pulse.
REQ-009 SHALL have port req, input, NUM_REQ, per-engine write request.
REQ-010 SHALL have port req_addr, input, NUM_REQ x ADDRWIDTH, per-engine SDRAM byte address.
REQ-011 SHALL have port req_data, input, NUM_REQ x DATAWIDTH, per-engine pixel word.
REQ-012 SHALL have port grant, output, NUM_REQ, one-hot single-cycle write-accepted pulse.
REQ-013 SHALL have port master_address, output, ADDRWIDTH, Avalon write address.
REQ-014 SHALL have port master_writedata, output, DATAWIDTH, Avalon write data.
REQ-015 SHALL have port master_write, output, 1, Avalon write strobe.
REQ-016 SHALL have port master_waitrequest, input, 1, Avalon stall.
REQ-017 SHALL have port busy, output, 1, high from frame accept until frame done.
REQ-018 SHALL have port frame_done, output, 1, single-cycle frame completion pulse.
REQ-019 SHALL have port pixel_count, output, CNTWIDTH, writes accepted in current frame.

Function
REQ-020 SHALL implement FSM with states IDLE, ARB, WRITE.
REQ-021 IDLE: busy=0, req ignored; frame_start=1 -> ARB next cycle, pixel_count cleared to 0.
REQ-022 ARB: busy=1; no req -> stay ARB; any req -> select one requester, register its req_addr/req_data, -> WRITE next cycle.
REQ-023 Selection SHALL be round-robin: first asserted req searching upward from (last_sel+1) mod NUM_REQ, wrapping.
REQ-024 WRITE: master_write=1, master_address/master_writedata = registered values, held stable while master_waitrequest=1.
REQ-025 WRITE with master_waitrequest=0: that cycle grant[sel]=1, pixel_count increments on clock edge, last_sel<=sel.
REQ-026 On accept, if pixel_count+1==FRAME_PIXELS: frame_done=1 next cycle, -> IDLE; else -> ARB.
REQ-027 Latency req-seen-in-ARB to master_write SHALL be exactly 1 cycle; min 2 cycles per accepted write.
REQ-028 Requesters SHALL hold req/addr/data until grant; req deasserted after ARB sampling does not cancel registered write.
REQ-029 master_write SHALL be 0, master_address/master_writedata SHALL be 0 outside WRITE.
REQ-030 frame_start while busy=1 SHALL be ignored, no count change.
REQ-031 grant SHALL never have more than one bit set; grant SHALL be 0 outside WRITE-accept cycle.
REQ-032 pixel_count SHALL hold final value in IDLE until next accepted frame_start.

Reset
REQ-033 reset_n=0 SHALL asynchronously force state IDLE, last_sel=NUM_REQ-1 (req[0] first priority), pixel_count=0, grant=0, master_write=0, master_address=0, master_writedata=0, busy=0, frame_done=0.
REQ-034 Reset asserted mid-WRITE SHALL drop master_write immediately; in-flight write not granted, not counted.

Verification
REQ-035 FRAME_PIXELS=4, frame_start, req=4'b0001 constant, waitrequest=0 -> grants to engine 0 at 2-cycle spacing, pixel_count 1..4, frame_done one cycle after 4th grant, busy falls.
REQ-036 req=4'b1111 constant -> grant sequence 0,1,2,3,0; master_address equals each granted engine's req_addr.
REQ-037 waitrequest=1 for 5 cycles in WRITE -> master_write, address, data stable 5 cycles, grant only on cycle waitrequest=0, count +1.
REQ-038 frame_start pulsed at pixel_count=2 while busy -> ignored, frame completes at FRAME_PIXELS.
REQ-039 reset_n low during WRITE with waitrequest=1 -> master_write=0 same cycle, pixel_count=0, no grant, IDLE after release.
REQ-040 last_sel=1, req=4'b0001 -> wrap-around grant to engine 0; then req=4'b0110 -> engine 1.

Source files
------------

// File: rtl/julia_write_arbiter.sv
// rtl/julia_write_arbiter.sv - round-robin arbiter funnelling Julia pixel-engine writes onto one Avalon write master
// Counts accepted writes per frame and pulses frame_done when the frame's last pixel is accepted.
module julia_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDRWIDTH    = 26,
  parameter int DATAWIDTH    = 32,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNTWIDTH     = 20
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_start,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [ADDRWIDTH-1:0]           master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  input  logic                           master_waitrequest,
  output logic                           busy,
  output logic                           frame_done,
  output logic [CNTWIDTH-1:0]            pixel_count
);

  localparam int                  SELW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SELW-1:0]     SEL_MAX    = SELW'(NUM_REQ - 1);
  localparam logic [SELW:0]       NUM_REQ_W  = (SELW + 1)'(NUM_REQ);
  localparam logic [CNTWIDTH-1:0] LAST_PIXEL = CNTWIDTH'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_WRITE
  } state_t;

  state_t                r_state;
  logic [SELW-1:0]       r_sel;
  logic [SELW-1:0]       r_last_sel;
  logic [CNTWIDTH-1:0]   r_pixel_count;
  logic                  r_master_write;
  logic [ADDRWIDTH-1:0]  r_master_address;
  logic [DATAWIDTH-1:0]  r_master_writedata;
  logic                  r_busy;
  logic                  r_frame_done;

  logic [SELW:0]         w_start;
  logic [2*NUM_REQ-1:0]  w_req2;
  logic [NUM_REQ-1:0]    w_rot;
  logic [SELW-1:0]       w_off;
  logic [SELW:0]         w_sum;
  logic [SELW-1:0]       w_sel;
  logic                  w_any;
  logic [ADDRWIDTH-1:0]  w_addr;
  logic [DATAWIDTH-1:0]  w_data;
  logic                  w_accept;
  logic [NUM_REQ-1:0]    w_grant;

  // Rotate req so bit 0 is the engine after last_sel; the lowest set bit then wins.
  always_comb begin
    w_start = {1'b0, r_last_sel} + 1'b1;
    w_req2  = {req, req} >> w_start;
    w_rot   = w_req2[NUM_REQ-1:0];
    w_any   = |w_rot;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = SELW'(k);
      end
    end
    w_sum = w_start + {1'b0, w_off};
    if (w_sum >= NUM_REQ_W) begin
      w_sum = w_sum - NUM_REQ_W;
    end
    w_sel = w_sum[SELW-1:0];
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_sel == SELW'(k)) begin
        w_addr = req_addr[k*ADDRWIDTH +: ADDRWIDTH];
        w_data = req_data[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign w_accept = (r_state == S_WRITE) && !master_waitrequest;

  always_comb begin
    w_grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_grant[k] = w_accept && (r_sel == SELW'(k));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= S_IDLE;
      r_sel              <= '0;
      r_last_sel         <= SEL_MAX;
      r_pixel_count      <= '0;
      r_master_write     <= 1'b0;
      r_master_address   <= '0;
      r_master_writedata <= '0;
      r_busy             <= 1'b0;
      r_frame_done       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state       <= S_ARB;
            r_busy        <= 1'b1;
            r_pixel_count <= '0;
          end
        end
        S_ARB: begin
          if (w_any) begin
            r_sel              <= w_sel;
            r_master_address   <= w_addr;
            r_master_writedata <= w_data;
            r_master_write     <= 1'b1;
            r_state            <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!master_waitrequest) begin
            r_master_write     <= 1'b0;
            r_master_address   <= '0;
            r_master_writedata <= '0;
            r_pixel_count      <= r_pixel_count + 1'b1;
            r_last_sel         <= r_sel;
            if (r_pixel_count == LAST_PIXEL) begin
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_ARB;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant            = w_grant;
  assign master_write     = r_master_write;
  assign master_address   = r_master_address;
  assign master_writedata = r_master_writedata;
  assign busy             = r_busy;
  assign frame_done       = r_frame_done;
  assign pixel_count      = r_pixel_count;

endmodule

// File: tb/tb_julia_write_arbiter.sv
// tb/tb_julia_write_arbiter.sv - self-checking bench for julia_write_arbiter
// Transaction-level model (pending-write queue, round-robin by modular search) plus directed tables.
module tb_julia_write_arbiter;

  localparam int NR = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int FP = 4;
  localparam int CW = 20;
  localparam logic [AW-1:0] A2 = 26'h2A5_5A54;
  localparam logic [DW-1:0] D2 = 32'hC0FF_EE02;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              frame_start;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     grant;
  logic [AW-1:0]     master_address;
  logic [DW-1:0]     master_writedata;
  logic              master_write;
  logic              master_waitrequest;
  logic              busy;
  logic              frame_done;
  logic [CW-1:0]     pixel_count;

  julia_write_arbiter #(
    .NUM_REQ(NR), .ADDRWIDTH(AW), .DATAWIDTH(DW), .FRAME_PIXELS(FP), .CNTWIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .req(req),
    .req_addr(req_addr), .req_data(req_data), .grant(grant),
    .master_address(master_address), .master_writedata(master_writedata),
    .master_write(master_write), .master_waitrequest(master_waitrequest),
    .busy(busy), .frame_done(frame_done), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int              sel;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
  } wr_t;

  typedef struct {
    logic            fs;
    logic [NR-1:0]   rq;
    logic            wr;
    logic [NR-1:0]   e_grant;
    logic            e_write;
    logic            e_busy;
    logic            e_done;
    int              e_cnt;
  } vec_t;

  // Model: a frame is active, at most one write is pending, and pixels are counted on accept.
  bit            m_active;
  wr_t           m_pend[$];
  int            m_count;
  int            m_last;
  bit            m_done;
  logic [NR-1:0] last_eg;
  int            grant_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] g);
    int r = -1;
    for (int i = 0; i < NR; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_pend.delete();
    m_count  = 0;
    m_last   = NR - 1;
    m_done   = 1'b0;
  endtask

  task automatic sample();
    logic [NR-1:0] eg;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            gi;
    @(negedge clk);
    if (!reset_n) model_reset();
    ew = (m_pend.size() != 0);
    eg = '0;
    ea = '0;
    ed = '0;
    if (ew) begin
      ea = m_pend[0].a;
      ed = m_pend[0].d;
      if (!master_waitrequest) eg[m_pend[0].sel] = 1'b1;
    end
    chk("grant", 64'(grant), 64'(eg));
    chk("master_write", 64'(master_write), 64'(ew));
    chk("master_address", 64'(master_address), 64'(ea));
    chk("master_writedata", 64'(master_writedata), 64'(ed));
    chk("busy", 64'(busy), 64'(m_active));
    chk("frame_done", 64'(frame_done), 64'(m_done));
    chk("pixel_count", 64'(pixel_count), 64'(m_count));
    chk("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
    last_eg = eg;
    if (grant != '0) begin
      gi = onehot_idx(grant);
      grant_log.push_back(gi);
      chk("grant_addr", 64'(master_address), 64'(req_addr[gi*AW +: AW]));
    end
  endtask

  task automatic advance();
    wr_t w;
    int  idx;
    @(posedge clk);
    if (reset_n) begin
      m_done = 1'b0;
      if (!m_active) begin
        if (frame_start) begin
          m_active = 1'b1;
          m_count  = 0;
        end
      end else if (m_pend.size() == 0) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (req[idx]) begin
            w.sel = idx;
            w.a   = req_addr[idx*AW +: AW];
            w.d   = req_data[idx*DW +: DW];
            m_pend.push_back(w);
            break;
          end
        end
      end else if (!master_waitrequest) begin
        w = m_pend.pop_front();
        m_count++;
        m_last = w.sel;
        if (m_count == FP) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    frame_start        = 1'b0;
    req                = '0;
    master_waitrequest = 1'b0;
    reset_n            = 1'b0;
    sample();
    advance();
    reset_n = 1'b1;
  endtask

  task automatic wait_grant(input string nm, input int exp);
    int  gi = -1;
    bit  got;
    for (int n = 0; n < 10; n++) begin
      sample();
      got = (grant != '0);
      if (got) gi = onehot_idx(grant);
      advance();
      if (got) break;
    end
    chk(nm, 64'(gi), 64'(exp));
  endtask

  task automatic new_word(input int i);
    req_addr[i*AW +: AW] = AW'($urandom);
    req_data[i*DW +: DW] = $urandom;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NR; i++) begin
      if (last_eg[i]) begin
        if ($urandom_range(1) == 0) req[i] = 1'b0;
        else new_word(i);
      end else if (!req[i] && $urandom_range(2) == 0) begin
        req[i] = 1'b1;
        new_word(i);
      end
    end
    master_waitrequest = ($urandom_range(3) == 0);
    frame_start        = ($urandom_range(3) == 0);
    if (!reset_n) reset_n = 1'b1;
    else if ($urandom_range(199) == 0) reset_n = 1'b0;
  endtask

  vec_t tbl[11];
  int   exp_rr[5];
  int   n;

  initial begin
    reset_n = 1'b0;
    frame_start = 1'b0;
    req = '0;
    master_waitrequest = 1'b0;
    last_eg = '0;
    for (int i = 0; i < NR; i++) new_word(i);
    model_reset();
    repeat (2) begin
      sample();
      advance();
    end
    reset_n = 1'b1;

    // Single requester, frame of four: two-cycle spacing, frame_start at count 2 ignored.
    tbl[0]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1};
    tbl[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 1};
    tbl[5]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 2};
    tbl[7]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3};
    tbl[8]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 3};
    tbl[9]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4};
    tbl[10] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4};
    for (int i = 0; i < 11; i++) begin
      frame_start        = tbl[i].fs;
      req                = tbl[i].rq;
      master_waitrequest = tbl[i].wr;
      sample();
      chk("tbl_grant", 64'(grant), 64'(tbl[i].e_grant));
      chk("tbl_write", 64'(master_write), 64'(tbl[i].e_write));
      chk("tbl_busy", 64'(busy), 64'(tbl[i].e_busy));
      chk("tbl_done", 64'(frame_done), 64'(tbl[i].e_done));
      chk("tbl_count", 64'(pixel_count), 64'(tbl[i].e_cnt));
      advance();
    end

    // All engines requesting: 0,1,2,3 then 0 again in the next frame.
    do_reset();
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'(32'h100 * (i + 1));
    grant_log.delete();
    req = 4'b1111;
    frame_start = 1'b1;
    sample();
    advance();
    frame_start = 1'b0;
    n = 0;
    while (grant_log.size() < 4 && n < 40) begin sample(); advance(); n++; end
    n = 0;
    while (m_active && n < 10) begin sample(); advance(); n++; end
    frame_start = 1'b1;
    sample();
    advance();
    frame_start = 1'b0;
    n = 0;
    while (grant_log.size() < 5 && n < 40) begin sample(); advance(); n++; end
    exp_rr = '{0, 1, 2, 3, 0};
    chk("rr_len", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_seq", 64'(grant_log[i]), 64'(exp_rr[i]));

    // Five stalled WRITE cycles hold the bus, then one accept.
    do_reset();
    req_addr[2*AW +: AW] = A2;
    req_data[2*DW +: DW] = D2;
    req = 4'b0100;
    master_waitrequest = 1'b1;
    frame_start = 1'b1;
    sample();
    advance();
    frame_start = 1'b0;
    sample();
    advance();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("stall_write", 64'(master_write), 64'd1);
      chk("stall_addr", 64'(master_address), 64'(A2));
      chk("stall_data", 64'(master_writedata), 64'(D2));
      chk("stall_grant", 64'(grant), 64'd0);
      advance();
    end
    master_waitrequest = 1'b0;
    sample();
    chk("accept_grant", 64'(grant), 64'b0100);
    chk("accept_count_pre", 64'(pixel_count), 64'd0);
    advance();
    req = '0;
    sample();
    chk("accept_count", 64'(pixel_count), 64'd1);
    chk("accept_write_drop", 64'(master_write), 64'd0);
    advance();

    // Reset while a write is stalled: drops immediately, nothing counted or granted.
    do_reset();
    req = 4'b0001;
    frame_start = 1'b1;
    sample();
    advance();
    frame_start = 1'b0;
    repeat (4) begin sample(); advance(); end
    master_waitrequest = 1'b1;
    sample();
    advance();
    sample();
    advance();
    chk("pre_rst_write", 64'(master_write), 64'd1);
    chk("pre_rst_count", 64'(pixel_count), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("rst_write", 64'(master_write), 64'd0);
    chk("rst_count", 64'(pixel_count), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    sample();
    advance();
    reset_n = 1'b1;
    master_waitrequest = 1'b0;
    repeat (2) begin
      sample();
      chk("post_rst_idle", 64'(busy), 64'd0);
      advance();
    end

    // Wrap from last_sel=1 to engine 0, then from 0 to engine 1.
    do_reset();
    req = 4'b0010;
    frame_start = 1'b1;
    sample();
    advance();
    frame_start = 1'b0;
    wait_grant("rr_first", 1);
    req = 4'b0001;
    wait_grant("rr_wrap", 0);
    req = 4'b0110;
    wait_grant("rr_next", 1);
    req = '0;

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
